// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the single-port SRAM arbiter: access sizes and
// the response-owner tag carried from issue to the data_ok cycle.
package sram_arb_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

endpackage

// File: rtl/sram_arbiter_if.sv
// Bundle of the fetch port, the load/store port and the SRAM port seen by the arbiter.
interface sram_arbiter_if #(parameter int ADDR_W = 32);

  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [31:0]       inst_rdata;

  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [31:0]       data_wdata;
  logic              data_addr_ok;
  logic              data_data_ok;
  logic [31:0]       data_rdata;
  logic              data_err;

  logic              mem_en;
  logic [3:0]        mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  inst_req, inst_addr,
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    input  mem_rdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    output data_addr_ok, data_data_ok, data_rdata, data_err,
    output mem_en, mem_wen, mem_addr, mem_wdata
  );

  modport master (
    output inst_req, inst_addr,
    output data_req, data_wr, data_size, data_addr, data_wdata,
    output mem_rdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_addr_ok, data_data_ok, data_rdata, data_err,
    input  mem_en, mem_wen, mem_addr, mem_wdata
  );

endinterface

// File: rtl/sram_arbiter_byte_en_gen.sv
// Byte-lane write enables and alignment check for one load/store request.
module byte_en_gen
  import sram_arb_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  input  logic       wr,
  output logic [3:0] wen,
  output logic       misalign
);

  always_comb begin
    wen      = 4'b0000;
    misalign = 1'b0;
    case (size)
      SZ_BYTE: wen = 4'b0001 << addr_lo;
      SZ_HALF: begin
        misalign = addr_lo[0];
        wen      = 4'b0011 << addr_lo;
      end
      SZ_WORD: begin
        misalign = |addr_lo;
        wen      = 4'b1111;
      end
      default: misalign = 1'b1;
    endcase
    // Loads and rejected requests never write.
    if (!wr || misalign) wen = 4'b0000;
  end

endmodule

// File: rtl/sram_arbiter.sv
// Serialises fetch and load/store requests onto one 1-cycle-latency SRAM;
// data has priority, a waiting fetch wins after STARVE_MAX data grants.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 2
) (
  input  logic           clk,
  input  logic           resetn,
  sram_arbiter_if.slave  bus
);

  localparam int              CNT_W     = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] WORD_MSK = ~ADDR_W'(3);

  logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
  owner_e           rsp_owner, rsp_owner_nxt;
  logic             rej_p1, rej_nxt;

  logic       grant_inst, grant_data, data_issue, misalign;
  logic [3:0] wen;

  byte_en_gen u_byte_en_gen (
    .size     (bus.data_size),
    .addr_lo  (bus.data_addr[1:0]),
    .wr       (bus.data_wr),
    .wen      (wen),
    .misalign (misalign)
  );

  always_comb begin
    grant_inst = resetn && bus.inst_req && (!bus.data_req || starve_cnt == CNT_MAX);
    grant_data = resetn && bus.data_req && !grant_inst;
    data_issue = grant_data && !misalign;

    bus.inst_addr_ok = grant_inst;
    bus.data_addr_ok = grant_data;
    bus.data_err     = grant_data && misalign;

    bus.mem_en    = grant_inst || data_issue;
    bus.mem_wen   = data_issue ? wen : 4'b0000;
    bus.mem_addr  = '0;
    if (grant_inst)      bus.mem_addr = bus.inst_addr & WORD_MSK;
    else if (data_issue) bus.mem_addr = bus.data_addr & WORD_MSK;
    bus.mem_wdata = (data_issue && bus.data_wr) ? bus.data_wdata : 32'h0;

    // Responses are owned by the previous cycle's issue; reset silences them at once.
    bus.inst_data_ok = resetn && (rsp_owner == OWN_INST);
    bus.data_data_ok = resetn && (rsp_owner == OWN_DATA);
    bus.inst_rdata   = bus.inst_data_ok ? bus.mem_rdata : 32'h0;
    bus.data_rdata   = (bus.data_data_ok && !rej_p1) ? bus.mem_rdata : 32'h0;

    rsp_owner_nxt = OWN_NONE;
    if (grant_inst)      rsp_owner_nxt = OWN_INST;
    else if (grant_data) rsp_owner_nxt = OWN_DATA;
    rej_nxt = grant_data && misalign;

    starve_cnt_nxt = starve_cnt;
    if (!bus.inst_req || grant_inst)
      starve_cnt_nxt = '0;
    else if (grant_data && starve_cnt != CNT_MAX)
      starve_cnt_nxt = starve_cnt + CNT_W'(1);
  end

  // ---- response stage boundary ----
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rsp_owner  <= OWN_NONE;
      starve_cnt <= '0;
      rej_p1     <= 1'b0;
    end else begin
      rsp_owner  <= rsp_owner_nxt;
      starve_cnt <= starve_cnt_nxt;
      rej_p1     <= rej_nxt;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed and randomized checks of sram_arbiter against a cycle-level reference model.
module tb_sram_arbiter;
  import sram_arb_pkg::*;

  localparam int ADDR_W     = 32;
  localparam int STARVE_MAX = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  sram_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Behavioural SRAM attached to the DUT, 64 words.
  logic [31:0] sram    [64];
  logic [31:0] ref_mem [64];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_wen == 4'b0000)
        bus.mem_rdata <= sram[bus.mem_addr[7:2]];
      else
        for (int b = 0; b < 4; b++)
          if (bus.mem_wen[b]) sram[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model state.
  bit          model_on = 1'b0;
  int          wait_cnt = 0;
  bit          exp_ir = 1'b0, exp_dr = 1'b0, exp_dchk = 1'b0;
  logic [31:0] exp_iv, exp_dv;
  bit          last_gi = 1'b0, last_gd = 1'b0;

  always @(negedge clk) begin
    if (model_on) begin
      if (!resetn) begin
        chk("rst_inst_addr_ok", bus.inst_addr_ok, 0);
        chk("rst_inst_data_ok", bus.inst_data_ok, 0);
        chk("rst_inst_rdata",   bus.inst_rdata,   0);
        chk("rst_data_addr_ok", bus.data_addr_ok, 0);
        chk("rst_data_data_ok", bus.data_data_ok, 0);
        chk("rst_data_rdata",   bus.data_rdata,   0);
        chk("rst_data_err",     bus.data_err,     0);
        chk("rst_mem_en",       bus.mem_en,       0);
        chk("rst_mem_wen",      bus.mem_wen,      0);
        chk("rst_mem_addr",     bus.mem_addr,     0);
        chk("rst_mem_wdata",    bus.mem_wdata,    0);
        wait_cnt = 0; exp_ir = 0; exp_dr = 0; exp_dchk = 0;
        last_gi = 0; last_gd = 0;
      end else begin
        bit          gi, gd, bad;
        int          nbytes, off;
        logic [3:0]  ewen;
        logic [31:0] eaddr;

        chk("inst_data_ok", bus.inst_data_ok, exp_ir);
        if (exp_ir) chk("inst_rdata", bus.inst_rdata, exp_iv);
        chk("data_data_ok", bus.data_data_ok, exp_dr);
        if (exp_dr && exp_dchk) chk("data_rdata", bus.data_rdata, exp_dv);

        gi = bus.inst_req && (!bus.data_req || wait_cnt >= STARVE_MAX);
        gd = bus.data_req && !gi;

        nbytes = (bus.data_size == 2'd0) ? 1 : (bus.data_size == 2'd1) ? 2 : 4;
        off    = int'(bus.data_addr[1:0]);
        bad    = (bus.data_size == 2'd3) || (off % nbytes != 0);

        ewen = 4'b0000;
        if (gd && bus.data_wr && !bad)
          for (int b = 0; b < 4; b++)
            if (b >= off && b < off + nbytes) ewen[b] = 1'b1;

        eaddr = 32'h0;
        if (gi)               eaddr = {bus.inst_addr[31:2], 2'b00};
        else if (gd && !bad)  eaddr = {bus.data_addr[31:2], 2'b00};

        chk("inst_addr_ok", bus.inst_addr_ok, gi);
        chk("data_addr_ok", bus.data_addr_ok, gd);
        chk("data_err",     bus.data_err,     gd && bad);
        chk("mem_en",       bus.mem_en,       gi || (gd && !bad));
        chk("mem_wen",      bus.mem_wen,      ewen);
        if (bus.mem_en) chk("mem_addr", bus.mem_addr, eaddr);
        if (gd && !bad && bus.data_wr) chk("mem_wdata_lanes", bus.mem_wdata & {{8{ewen[3]}},{8{ewen[2]}},{8{ewen[1]}},{8{ewen[0]}}},
                                           bus.data_wdata & {{8{ewen[3]}},{8{ewen[2]}},{8{ewen[1]}},{8{ewen[0]}}});

        exp_ir = gi;
        if (gi) exp_iv = ref_mem[bus.inst_addr[7:2]];
        exp_dr   = gd;
        exp_dchk = gd && (bad || !bus.data_wr);
        exp_dv   = bad ? 32'h0 : ref_mem[bus.data_addr[7:2]];
        if (gd && bus.data_wr && !bad)
          for (int b = 0; b < 4; b++)
            if (ewen[b]) ref_mem[bus.data_addr[7:2]][8*b +: 8] = bus.data_wdata[8*b +: 8];

        if (!bus.inst_req || gi) wait_cnt = 0;
        else if (gd && wait_cnt < STARVE_MAX) wait_cnt++;
        last_gi = gi;
        last_gd = gd;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.inst_req = 0; bus.inst_addr = '0;
    bus.data_req = 0; bus.data_wr = 0; bus.data_size = 2'd2;
    bus.data_addr = '0; bus.data_wdata = '0;
  endtask

  task automatic set_data(input bit wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    bus.data_req = 1; bus.data_wr = wr; bus.data_size = sz;
    bus.data_addr = a; bus.data_wdata = wd;
  endtask

  logic [1:0] pat [6];

  initial begin
    idle();
    for (int i = 0; i < 64; i++) begin
      sram[i] = $urandom;
      ref_mem[i] = sram[i];
    end
    sram[0] = 32'h3C1D0000; ref_mem[0] = 32'h3C1D0000;
    sram[1] = 32'h11112222; ref_mem[1] = 32'h11112222;
    sram[2] = 32'h33334444; ref_mem[2] = 32'h33334444;
    bus.mem_rdata = '0;

    @(posedge clk);
    model_on = 1;
    // Requests asserted during reset must not be granted.
    bus.inst_req = 1; bus.inst_addr = 32'hBFC00000;
    set_data(0, 2'd2, 32'h80000000, 0);
    repeat (2) cyc();
    idle();
    resetn = 1;
    cyc();

    // Lone fetch.
    bus.inst_req = 1; bus.inst_addr = 32'hBFC00000;
    @(negedge clk);
    chk("fetch_addr_ok", bus.inst_addr_ok, 1);
    chk("fetch_wen", bus.mem_wen, 0);
    cyc(); idle();
    @(negedge clk);
    chk("fetch_data_ok", bus.inst_data_ok, 1);
    chk("fetch_rdata", bus.inst_rdata, 32'h3C1D0000);
    cyc();

    // Store byte to the top lane.
    set_data(1, SZ_BYTE, 32'h80000003, 32'hAB000000);
    @(negedge clk);
    chk("sb_wen", bus.mem_wen, 4'b1000);
    chk("sb_addr", bus.mem_addr, 32'h80000000);
    cyc(); idle();
    @(negedge clk);
    chk("sb_data_ok", bus.data_data_ok, 1);
    cyc();

    // Both ports held: starvation rule sets the grant order.
    pat[0] = 2'b01; pat[1] = 2'b01; pat[2] = 2'b10;
    pat[3] = 2'b01; pat[4] = 2'b01; pat[5] = 2'b10;
    bus.inst_req = 1; bus.inst_addr = 32'hBFC00008;
    set_data(0, SZ_WORD, 32'h80000004, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("grant_pat%0d", k), {bus.inst_addr_ok, bus.data_addr_ok}, pat[k]);
      cyc();
    end
    idle();
    cyc();

    // Misaligned half load is rejected.
    set_data(0, SZ_HALF, 32'h80000001, 0);
    @(negedge clk);
    chk("lh_err", bus.data_err, 1);
    chk("lh_addr_ok", bus.data_addr_ok, 1);
    chk("lh_mem_en", bus.mem_en, 0);
    cyc(); idle();
    @(negedge clk);
    chk("lh_data_ok", bus.data_data_ok, 1);
    chk("lh_rdata", bus.data_rdata, 0);
    cyc();

    // Fetch cut off by reset in the following cycle.
    bus.inst_req = 1; bus.inst_addr = 32'hBFC00010;
    @(negedge clk);
    chk("rstfetch_addr_ok", bus.inst_addr_ok, 1);
    cyc(); idle(); resetn = 0;
    @(negedge clk);
    chk("rstfetch_data_ok", bus.inst_data_ok, 0);
    cyc(); resetn = 1;
    @(negedge clk);
    chk("rstfetch_after", bus.inst_data_ok, 0);
    cyc();

    // Back-to-back word loads.
    for (int k = 0; k < 4; k++) begin
      if (k < 3) set_data(0, SZ_WORD, 32'h80000000 + 32'(4 * k), 0);
      else idle();
      @(negedge clk);
      if (k < 3) chk($sformatf("b2b_addr_ok%0d", k), bus.data_addr_ok, 1);
      if (k > 0) begin
        chk($sformatf("b2b_data_ok%0d", k - 1), bus.data_data_ok, 1);
        chk($sformatf("b2b_rdata%0d", k - 1), bus.data_rdata, ref_mem[k - 1]);
      end
      cyc();
    end
    idle();
    cyc();

    // Randomized traffic; requesters hold until accepted.
    for (int n = 0; n < 3000; n++) begin
      if (!bus.inst_req || last_gi) begin
        bus.inst_req  = ($urandom_range(0, 2) != 0);
        bus.inst_addr = 32'hBFC00000 | (32'($urandom_range(0, 63)) << 2);
      end
      if (!bus.data_req || last_gd) begin
        bus.data_req   = ($urandom_range(0, 2) != 0);
        bus.data_wr    = $urandom_range(0, 1) != 0;
        bus.data_size  = 2'($urandom_range(0, 3));
        bus.data_addr  = 32'h80000000 | 32'($urandom_range(0, 255));
        bus.data_wdata = $urandom;
      end
      resetn = ($urandom_range(0, 199) != 0);
      cyc();
    end
    resetn = 1;
    idle();
    repeat (2) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
